// File: rtl/dff_universal_reg.sv
// -----------------------------------------------------------------------------
// dff_universal_reg
//
// General-purpose WIDTH-bit storage / serialisation register. It replaces
// arrays of single-bit DFFs and supports hold, synchronous clear, parallel
// load, and shift right/left. A shift either takes its fill bit from a serial
// input or rotates the end bit back in, chosen by ROTATE. A registered
// 'changed' flag pulses for one cycle after any edge that altered q.
//
// Parameters:
//   WIDTH      number of register bits (>= 2)
//   RESET_VAL  value forced onto q while rst_n is low
//   ROTATE     0: shifts fill from sin_msb / sin_lsb
//              1: shifts wrap the outgoing end bit around
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   en        clock enable (0 = hold, unless clr=1)
//   clr       synchronous clear to zero, highest priority
//   mode      00 hold, 01 shift right, 10 shift left, 11 parallel load
//   d         parallel load data
//   sin_msb   fill bit entering q[WIDTH-1] on shift right (ROTATE=0)
//   sin_lsb   fill bit entering q[0] on shift left (ROTATE=0)
//   q         register contents
//   qbar      bitwise complement of q
//   sout_lsb  q[0], the bit leaving on shift right
//   sout_msb  q[WIDTH-1], the bit leaving on shift left
//   changed   high for one cycle after an edge that altered q
// -----------------------------------------------------------------------------
module dff_universal_reg #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
  parameter bit               ROTATE    = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_msb,
  input  logic             sin_lsb,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             sout_lsb,
  output logic             sout_msb,
  output logic             changed
);

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  function automatic logic [WIDTH-1:0] shift_right(input logic [WIDTH-1:0] v,
                                                   input logic             fill);
    return {fill, v[WIDTH-1:1]};
  endfunction

  function automatic logic [WIDTH-1:0] shift_left(input logic [WIDTH-1:0] v,
                                                  input logic             fill);
    return {v[WIDTH-2:0], fill};
  endfunction

  logic [WIDTH-1:0] next_q;
  logic             fill_r;
  logic             fill_l;

  // In rotate mode the bit falling off one end re-enters at the other.
  assign fill_r = ROTATE ? q[0]       : sin_msb;
  assign fill_l = ROTATE ? q[WIDTH-1] : sin_lsb;

  always_comb begin
    next_q = q;
    if (clr) begin
      next_q = '0;
    end else if (en) begin
      case (mode)
        MODE_HOLD: next_q = q;
        MODE_SHR:  next_q = shift_right(q, fill_r);
        MODE_SHL:  next_q = shift_left(q, fill_l);
        MODE_LOAD: next_q = d;
        default:   next_q = q;
      endcase
    end
  end

  // 'changed' compares against the value being replaced, so loads of an
  // identical value, self-similar shifts and redundant clears leave it low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q       <= RESET_VAL;
      changed <= 1'b0;
    end else begin
      q       <= next_q;
      changed <= (next_q != q);
    end
  end

  // Purely combinational from q, so qbar can never disagree with q,
  // including while reset is held.
  assign qbar     = ~q;
  assign sout_lsb = q[0];
  assign sout_msb = q[WIDTH-1];

endmodule

// File: tb/tb_dff_universal_reg.sv
// -----------------------------------------------------------------------------
// tb_dff_universal_reg
//
// Drives a shift-mode (ROTATE=0) and a rotate-mode (ROTATE=1) instance with
// identical inputs. Expected results are queued when stimulus is applied and
// compared after the following rising edge.
// -----------------------------------------------------------------------------
module tb_dff_universal_reg;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       clr;
  logic [1:0] mode;
  logic [7:0] d;
  logic       sin_msb;
  logic       sin_lsb;

  logic [7:0] q0, qb0, q1, qb1;
  logic       sl0, sm0, ch0, sl1, sm1, ch1;

  int total = 0;
  int passed = 0;

  dff_universal_reg #(.WIDTH(8), .RESET_VAL(8'hA5), .ROTATE(1'b0)) dut_shift (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .mode(mode), .d(d),
    .sin_msb(sin_msb), .sin_lsb(sin_lsb), .q(q0), .qbar(qb0),
    .sout_lsb(sl0), .sout_msb(sm0), .changed(ch0)
  );

  dff_universal_reg #(.WIDTH(8), .RESET_VAL(8'hA5), .ROTATE(1'b1)) dut_rot (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .mode(mode), .d(d),
    .sin_msb(sin_msb), .sin_lsb(sin_lsb), .q(q1), .qbar(qb1),
    .sout_lsb(sl1), .sout_msb(sm1), .changed(ch1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       clr;
    logic       en;
    logic [1:0] mode;
    logic [7:0] d;
    logic       smsb;
    logic       slsb;
    logic [7:0] q0;
    logic       ch0;
    logic [7:0] q1;
    logic       ch1;
  } vec_t;

  typedef struct {
    logic [7:0] q0;
    logic       ch0;
    logic [7:0] q1;
    logic       ch1;
  } exp_t;

  vec_t vecs[17];
  exp_t sb[$];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic chk_inst(input string tag,
                          input logic [7:0] aq, input logic [7:0] aqb,
                          input logic asl, input logic asm, input logic ach,
                          input logic [7:0] eq, input logic ech);
    logic [7:0] eqb;
    eqb = ~eq;
    chk({tag, ".q"},        aq,  eq);
    chk({tag, ".qbar"},     aqb, eqb);
    chk({tag, ".sout_lsb"}, {7'd0, asl}, {7'd0, eq[0]});
    chk({tag, ".sout_msb"}, {7'd0, asm}, {7'd0, eq[7]});
    chk({tag, ".changed"},  {7'd0, ach}, {7'd0, ech});
  endtask

  // Apply inputs on the falling edge and queue what the next rising edge
  // must produce.
  task automatic drive(input logic c, input logic e, input logic [1:0] m,
                       input logic [7:0] dd, input logic smsb, input logic slsb,
                       input logic [7:0] eq0, input logic ech0,
                       input logic [7:0] eq1, input logic ech1);
    exp_t x;
    @(negedge clk);
    clr = c; en = e; mode = m; d = dd; sin_msb = smsb; sin_lsb = slsb;
    x.q0 = eq0; x.ch0 = ech0; x.q1 = eq1; x.ch1 = ech1;
    sb.push_back(x);
  endtask

  task automatic collect(input string tag);
    exp_t x;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      total++;
      $display("FAIL %s: scoreboard empty, got q0=%h expected an entry", tag, q0);
    end else begin
      x = sb.pop_front();
      chk_inst({tag, ".shift"}, q0, qb0, sl0, sm0, ch0, x.q0, x.ch0);
      chk_inst({tag, ".rot"},   q1, qb1, sl1, sm1, ch1, x.q1, x.ch1);
    end
  endtask

  initial begin
    logic [7:0] e0, prev0, e1;
    logic       rs, rm;

    //               clr   en    mode  d      smsb  slsb  q0     ch0   q1     ch1
    vecs[0]  = '{1'b0, 1'b1, 2'd3, 8'h3C, 1'b0, 1'b0, 8'h3C, 1'b1, 8'h3C, 1'b1}; // load
    vecs[1]  = '{1'b0, 1'b1, 2'd0, 8'h00, 1'b0, 1'b0, 8'h3C, 1'b0, 8'h3C, 1'b0}; // hold
    vecs[2]  = '{1'b0, 1'b1, 2'd0, 8'h00, 1'b0, 1'b0, 8'h3C, 1'b0, 8'h3C, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 2'd1, 8'h00, 1'b1, 1'b1, 8'h3C, 1'b0, 8'h3C, 1'b0}; // en=0
    vecs[4]  = '{1'b0, 1'b1, 2'd3, 8'h81, 1'b0, 1'b0, 8'h81, 1'b1, 8'h81, 1'b1};
    vecs[5]  = '{1'b0, 1'b1, 2'd1, 8'h00, 1'b0, 1'b0, 8'h40, 1'b1, 8'hC0, 1'b1}; // shr
    vecs[6]  = '{1'b0, 1'b1, 2'd2, 8'h00, 1'b0, 1'b1, 8'h81, 1'b1, 8'h81, 1'b1}; // shl
    vecs[7]  = '{1'b0, 1'b1, 2'd2, 8'h00, 1'b0, 1'b1, 8'h03, 1'b1, 8'h03, 1'b1};
    vecs[8]  = '{1'b0, 1'b1, 2'd3, 8'hFF, 1'b0, 1'b0, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 2'd1, 8'h00, 1'b1, 1'b0, 8'hFF, 1'b0, 8'hFF, 1'b0}; // same pattern
    vecs[10] = '{1'b1, 1'b0, 2'd3, 8'h12, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b1}; // clr wins
    vecs[11] = '{1'b1, 1'b0, 2'd3, 8'h12, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0}; // clr on 0
    vecs[12] = '{1'b0, 1'b0, 2'd3, 8'h12, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0}; // en=0 hold
    vecs[13] = '{1'b0, 1'b1, 2'd3, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0}; // same load
    vecs[14] = '{1'b0, 1'b1, 2'd3, 8'h5A, 1'b0, 1'b0, 8'h5A, 1'b1, 8'h5A, 1'b1};
    vecs[15] = '{1'b0, 1'b1, 2'd2, 8'h00, 1'b1, 1'b0, 8'hB4, 1'b1, 8'hB4, 1'b1};
    vecs[16] = '{1'b0, 1'b1, 2'd1, 8'h00, 1'b1, 1'b1, 8'hDA, 1'b1, 8'h5A, 1'b1};

    rst_n = 1'b1; en = 1'b0; clr = 1'b0; mode = 2'd0; d = 8'h00;
    sin_msb = 1'b0; sin_lsb = 1'b0;

    // Asynchronous reset asserted between edges takes effect immediately.
    #12;
    rst_n = 1'b0;
    #1;
    chk_inst("reset.shift", q0, qb0, sl0, sm0, ch0, 8'hA5, 1'b0);
    chk_inst("reset.rot",   q1, qb1, sl1, sm1, ch1, 8'hA5, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].clr, vecs[i].en, vecs[i].mode, vecs[i].d, vecs[i].smsb,
            vecs[i].slsb, vecs[i].q0, vecs[i].ch0, vecs[i].q1, vecs[i].ch1);
      collect($sformatf("vec%0d", i));
    end

    // Eight left shifts from 8'h01 with noisy serial inputs: the rotating
    // instance walks the one-hot bit around and ignores them.
    drive(1'b0, 1'b1, 2'd3, 8'h01, 1'b0, 1'b0, 8'h01, 1'b1, 8'h01, 1'b1);
    collect("rot_load");
    e0 = 8'h01;
    for (int k = 0; k < 8; k++) begin
      rs = 1'($urandom_range(0, 1));
      rm = 1'($urandom_range(0, 1));
      prev0 = e0;
      e0 = {prev0[6:0], rs};
      e1 = 8'h01 << ((k + 1) % 8);
      drive(1'b0, 1'b1, 2'd2, 8'h00, rm, rs, e0, (e0 != prev0), e1, 1'b1);
      collect($sformatf("rot%0d", k));
    end

    // Reset pulsed mid-load: aborts the load, next edge starts from A5.
    @(negedge clk);
    clr = 1'b0; en = 1'b1; mode = 2'd3; d = 8'hFF;
    #1;
    rst_n = 1'b0;
    #1;
    chk_inst("midrst.shift", q0, qb0, sl0, sm0, ch0, 8'hA5, 1'b0);
    chk_inst("midrst.rot",   q1, qb1, sl1, sm1, ch1, 8'hA5, 1'b0);
    mode = 2'd2; sin_lsb = 1'b1; sin_msb = 1'b0;
    sb.push_back('{8'h4B, 1'b1, 8'h4B, 1'b1});
    #2;
    rst_n = 1'b1;
    collect("after_rst");

    drive(1'b0, 1'b1, 2'd0, 8'h00, 1'b0, 1'b0, 8'h4B, 1'b0, 8'h4B, 1'b0);
    collect("final_hold");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/dff_universal_reg.md
Name: dff_universal_reg

Overview:
Parametrised successor to the single-bit D flip-flop. It is a WIDTH-bit register with complementary outputs, hold, synchronous clear, parallel load, and left/right shift or rotate. It also has a registered change flag. It serves as the general-purpose storage and serialisation element for datapaths that currently instantiate arrays of single-bit DFFs.

Parameters:
WIDTH, 8, number of register bits; legal range ≥2
RESET_VAL, {WIDTH{1'b0}}, value loaded into q on asynchronous reset
ROTATE, 0, 0 = shifts take fill bits from the serial inputs; 1 = shifts wrap the end-of-register bit around and ignore the serial inputs

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
en  input  1  clock enable; 0 = hold, unless clr=1
clr  input  1  synchronous clear to all-zero; takes priority over en and mode
mode  input  2  00 hold, 01 shift right, 10 shift left, 11 parallel load
d  input  WIDTH  parallel load data
sin_msb  input  1  fill bit entering q[WIDTH-1] on shift right (ROTATE=0)
sin_lsb  input  1  fill bit entering q[0] on shift left (ROTATE=0)
q  output  WIDTH  register contents
qbar  output  WIDTH  bitwise complement of q
sout_lsb  output  1  q[0], the bit leaving on shift right
sout_msb  output  1  q[WIDTH-1], the bit leaving on shift left
changed  output  1  1 for exactly one cycle after any edge that altered q

Behaviour:
- Reset: while rst_n=0, asynchronously q=RESET_VAL, qbar=~RESET_VAL, changed=0.
- Reset is released synchronously at the next clk edge. On that edge the register operates normally.
- Priority per rising clk edge: clr > en=0 > mode.
- clr=1: q<=0, regardless of en and mode.
- en=0 (and clr=0): q holds.
- mode 00: q holds.
- mode 01, shift right: q<={fill, q[WIDTH-1:1]}. fill=sin_msb when ROTATE=0, q[0] when ROTATE=1.
- mode 10, shift left: q<={q[WIDTH-2:0], fill}. fill=sin_lsb when ROTATE=0, q[WIDTH-1] when ROTATE=1.
- mode 11: q<=d.
- Latency: every q update is visible one edge after the inputs are sampled. There is no combinational path from d, the serial inputs or mode to q.
- qbar, sout_lsb and sout_msb are derived purely from q.
- qbar==~q holds at every instant, including during reset. No glitch cycle where qbar and q disagree is permitted.
- changed is a registered flag, set to (next_q != q) on each edge, so it stays low on:
  - holds;
  - a load of an identical value;
  - shifts that produce the same pattern (e.g. all-ones with fill=1);
  - a clr while q is already 0.
- An edge with no change drops changed back to 0.
- Reset asserted mid-operation aborts any shift or load at once. The first edge after release behaves as from RESET_VAL.
- With ROTATE=1, WIDTH successive shifts in one direction return q to its original value.

Test Plan:
- Reset: WIDTH=8, RESET_VAL=8'hA5, rst_n=0 asynchronously between edges -> q=8'hA5, qbar=8'h5A and changed=0 immediately, before any clk edge.
- Load then hold: mode=11, d=8'h3C, en=1 for one edge -> q=8'h3C, changed=1. Then mode=00 for 3 edges -> q stays 8'h3C, changed=0 from the 2nd edge onward.
- Shift with fill (ROTATE=0): from q=8'h81, mode=01, sin_msb=0 -> q=8'h40, sout_lsb=0. Then mode=10, sin_lsb=1 for 2 edges -> 8'h81 then 8'h03.
- Rotate (ROTATE=1): from q=8'h01, shift left 8 edges -> q goes 02,04,...,80,01 and changed=1 every edge. Serial inputs toggling randomly have no effect.
- Priority: q=8'hFF, clr=1, en=0, mode=11, d=8'h12 -> q=8'h00, changed=1. Repeat clr -> changed=0. en=0, mode=11 -> q holds.
- Reset mid-op: loading 8'hFF with rst_n pulsed low for 3 ns between edges -> q=RESET_VAL at once. The next edge with mode=10, sin_lsb=1 and RESET_VAL=8'hA5 -> q=8'h4B.
